// File: rtl/pwm_capture_pkg.sv
// Shared defaults and state encoding for the PWM capture block.
package pwm_capture_pkg;

  localparam int unsigned DEF_WIDTH       = 16;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } cap_state_e;

endpackage

// File: rtl/pwm_capture_if.sv
// Control inputs and measurement results of pwm_capture, grouped as one bundle.
interface pwm_capture_if
  import pwm_capture_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) ();

  logic             enable;
  logic             pwm_in;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             valid;
  logic             overflow;
  logic             timeout;
  logic             level;

  modport master (
    output enable, pwm_in,
    input  period, high_time, valid, overflow, timeout, level
  );

  modport slave (
    input  enable, pwm_in,
    output period, high_time, valid, overflow, timeout, level
  );

endinterface

// File: rtl/pwm_capture_sync_edge.sv
// Synchroniser chain for the asynchronous PWM pin plus a delay flop for rising-edge detect.
module pwm_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise_c
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level  = r_sync[SYNC_STAGES-1];
  assign o_rise_c = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/pwm_capture.sv
// Measures rise-to-rise period and high time of an asynchronous PWM input in clk cycles.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic          clk,
  input  logic          reset_n,
  pwm_capture_if.slave  bus
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  cap_state_e       r_state;
  cap_state_e       w_state_nxt;
  logic [WIDTH-1:0] r_pcnt;
  logic [WIDTH-1:0] r_hcnt;
  logic [WIDTH-1:0] w_pcnt_nxt;
  logic [WIDTH-1:0] w_hcnt_nxt;
  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_high_time;
  logic             r_valid;
  logic             r_overflow;
  logic             r_timeout;
  logic             w_capture;
  logic             w_level;
  logic             w_rise;

  pwm_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_async  (bus.pwm_in),
    .o_level  (w_level),
    .o_rise_c (w_rise)
  );

  // Arming and saturating counters; a rise restarts the interval at 1 (the rise cycle itself).
  always_comb begin
    w_state_nxt = r_state;
    w_pcnt_nxt  = r_pcnt;
    w_hcnt_nxt  = r_hcnt;
    w_capture   = 1'b0;
    if (!bus.enable) begin
      w_state_nxt = ST_IDLE;
      w_pcnt_nxt  = '0;
      w_hcnt_nxt  = '0;
    end else if (w_rise) begin
      w_capture   = (r_state == ST_ARMED);
      w_state_nxt = ST_ARMED;
      w_pcnt_nxt  = WIDTH'(1);
      w_hcnt_nxt  = WIDTH'(1);
    end else begin
      if (r_pcnt != CNT_MAX) begin
        w_pcnt_nxt = r_pcnt + WIDTH'(1);
      end
      if (w_level && (r_hcnt != CNT_MAX)) begin
        w_hcnt_nxt = r_hcnt + WIDTH'(1);
      end
    end
  end

  // Timeout is registered from next-state values so it tracks armed & saturated pcnt exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_pcnt      <= '0;
      r_hcnt      <= '0;
      r_period    <= '0;
      r_high_time <= '0;
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pcnt    <= w_pcnt_nxt;
      r_hcnt    <= w_hcnt_nxt;
      r_valid   <= w_capture;
      r_timeout <= (w_state_nxt == ST_ARMED) && (w_pcnt_nxt == CNT_MAX);
      if (w_capture) begin
        r_period    <= r_pcnt;
        r_high_time <= r_hcnt;
        r_overflow  <= (r_pcnt == CNT_MAX);
      end
    end
  end

  assign bus.period    = r_period;
  assign bus.high_time = r_high_time;
  assign bus.valid     = r_valid;
  assign bus.overflow  = r_overflow;
  assign bus.timeout   = r_timeout;
  assign bus.level     = w_level;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench: a 16-bit and a 4-bit pwm_capture share one driven PWM pin.
module tb_pwm_capture;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic pin     = 1'b0;
  logic en      = 1'b0;

  always #5 clk = ~clk;

  pwm_capture_if #(.WIDTH(16)) bus_w ();
  pwm_capture_if #(.WIDTH(4))  bus_n ();

  assign bus_w.enable = en;
  assign bus_w.pwm_in = pin;
  assign bus_n.enable = en;
  assign bus_n.pwm_in = pin;

  pwm_capture #(.WIDTH(16), .SYNC_STAGES(2)) u_w (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_w)
  );

  pwm_capture #(.WIDTH(4), .SYNC_STAGES(2)) u_n (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_n)
  );

  int checks = 0;
  int errors = 0;

  // Capture log, sampled mid-cycle
  int          w_cnt   = 0;
  int          n_cnt   = 0;
  logic [15:0] w_per   = '0;
  logic [15:0] w_hi    = '0;
  logic        w_ovf   = 1'b0;
  logic [3:0]  n_per   = '0;
  logic [3:0]  n_hi    = '0;
  logic        n_ovf   = 1'b0;
  logic        w_prev  = 1'b0;
  logic        w_consec = 1'b0;
  logic        w_hi_gt  = 1'b0;

  always @(negedge clk) begin
    if (bus_w.valid) begin
      w_cnt = w_cnt + 1;
      w_per = bus_w.period;
      w_hi  = bus_w.high_time;
      w_ovf = bus_w.overflow;
      if (w_prev) w_consec = 1'b1;
      if (bus_w.high_time > bus_w.period) w_hi_gt = 1'b1;
    end
    if (bus_n.valid) begin
      n_cnt = n_cnt + 1;
      n_per = bus_n.period;
      n_hi  = bus_n.high_time;
      n_ovf = bus_n.overflow;
    end
    w_prev = bus_w.valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int h, input int l);
    pin = 1'b1;
    cyc(h);
    pin = 1'b0;
    cyc(l);
  endtask

  int base;

  initial begin
    // Reset state
    cyc(3);
    check("rst_period",    32'(bus_w.period),    32'd0);
    check("rst_high_time", 32'(bus_w.high_time), 32'd0);
    check("rst_valid",     32'(bus_w.valid),     32'd0);
    check("rst_timeout",   32'(bus_w.timeout),   32'd0);
    reset_n = 1'b1;
    en      = 1'b1;
    cyc(2);

    // Period 256, high 65: first rise only arms
    base = w_cnt;
    repeat (4) pulse(65, 191);
    pin = 1'b1;
    cyc(5);
    check("t1_count",    32'(w_cnt - base),   32'd4);
    check("t1_period",   32'(w_per),          32'd256);
    check("t1_high",     32'(w_hi),           32'd65);
    check("t1_overflow", 32'(w_ovf),          32'd0);
    check("t1_timeout",  32'(bus_w.timeout),  32'd0);
    pin = 1'b0;
    cyc(10);

    // 3/7 pattern then switch to 7/3
    base = w_cnt;
    repeat (4) pulse(3, 7);
    pin = 1'b1;
    cyc(5);
    check("t2_count", 32'(w_cnt - base), 32'd5);
    check("t2_period_a", 32'(w_per), 32'd10);
    check("t2_high_a",   32'(w_hi),  32'd3);
    cyc(2);
    pin = 1'b0;
    cyc(3);
    repeat (2) pulse(7, 3);
    pin = 1'b1;
    cyc(5);
    check("t2_period_b", 32'(w_per), 32'd10);
    check("t2_high_b",   32'(w_hi),  32'd7);
    pin = 1'b0;
    cyc(10);

    // Period 20 / high 5: saturates the 4-bit instance
    repeat (3) pulse(5, 15);
    check("t4_n_timeout_pre", 32'(bus_n.timeout), 32'd1);
    check("t4_w_timeout_pre", 32'(bus_w.timeout), 32'd0);
    pin = 1'b1;
    cyc(5);
    check("t4_n_period",   32'(n_per),         32'd15);
    check("t4_n_high",     32'(n_hi),          32'd5);
    check("t4_n_overflow", 32'(n_ovf),         32'd1);
    check("t4_n_timeout",  32'(bus_n.timeout), 32'd0);
    check("t4_w_period",   32'(w_per),         32'd20);
    check("t4_w_high",     32'(w_hi),          32'd5);
    check("t4_w_overflow", 32'(w_ovf),         32'd0);

    // Stuck high after arming
    base = n_cnt;
    cyc(30);
    check("t3_n_novalid", 32'(n_cnt - base),   32'd0);
    check("t3_n_timeout", 32'(bus_n.timeout),  32'd1);
    check("t3_n_level",   32'(bus_n.level),    32'd1);
    check("t3_w_timeout", 32'(bus_w.timeout),  32'd0);
    check("t3_w_level",   32'(bus_w.level),    32'd1);
    pin = 1'b0;
    cyc(10);

    // Minimum period of 2
    base = w_cnt;
    repeat (6) pulse(1, 1);
    pin = 1'b1;
    cyc(5);
    check("tmin_count",  32'(w_cnt - base), 32'd7);
    check("tmin_period", 32'(w_per),        32'd2);
    check("tmin_high",   32'(w_hi),         32'd1);
    check("tmin_consec", 32'(w_consec),     32'd0);
    pin = 1'b0;
    cyc(10);

    // Asynchronous reset mid-period
    repeat (2) pulse(3, 7);
    pin = 1'b1;
    cyc(2);
    reset_n = 1'b0;
    #1;
    check("t5_period",   32'(bus_w.period),    32'd0);
    check("t5_high",     32'(bus_w.high_time), 32'd0);
    check("t5_valid",    32'(bus_w.valid),     32'd0);
    check("t5_overflow", 32'(bus_n.overflow),  32'd0);
    check("t5_timeout",  32'(bus_w.timeout),   32'd0);
    check("t5_level",    32'(bus_w.level),     32'd0);
    pin = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    cyc(5);
    base = w_cnt;
    pulse(3, 7);
    check("t5_arm_only", 32'(w_cnt - base), 32'd0);
    pulse(3, 7);
    check("t5_count",    32'(w_cnt - base),   32'd1);
    check("t5_period_c", 32'(w_per),          32'd10);
    check("t5_high_c",   32'(w_hi),           32'd3);
    check("t5_period_o", 32'(bus_w.period),   32'd10);
    pin = 1'b1;
    cyc(5);
    pin = 1'b0;
    cyc(10);

    // Enable low for 50 cycles, then re-enable
    en   = 1'b0;
    base = w_cnt;
    repeat (5) pulse(3, 7);
    check("t6_novalid",   32'(w_cnt - base),      32'd0);
    check("t6_timeout",   32'(bus_n.timeout),     32'd0);
    check("t6_hold_per",  32'(bus_w.period),      32'd10);
    check("t6_hold_high", 32'(bus_w.high_time),   32'd3);
    en = 1'b1;
    cyc(2);
    pulse(4, 6);
    check("t6_arm_only", 32'(w_cnt - base), 32'd0);
    pulse(4, 6);
    check("t6_count",  32'(w_cnt - base), 32'd1);
    check("t6_period", 32'(w_per),        32'd10);
    check("t6_high",   32'(w_hi),         32'd4);

    check("high_le_period", 32'(w_hi_gt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
